data_mem_bridge: RTL and testbench

Data-side memory stage directly downstream of the pipelined CPU core. It consumes the core's memory-stage bus (MemWrite, ALUResult, WriteData) and returns ReadData. It holds the word-addressed data RAM and one memory-mapped status register. When the core raises FlagZero (program done), an internal dump FSM streams a fixed RAM window out as bytes over a valid/ready interface to the display/UART consumer.

---
 rtl/mem_bridge_pkg.sv | 17 +
 rtl/data_mem_bridge_dp_ram.sv | 26 ++
 rtl/data_mem_bridge.sv | 134 +++++++++++++
 tb/tb_data_mem_bridge.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the data-side memory bridge.
// Imported by the bridge top and its RAM.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } dump_state_t;

  localparam logic [31:0] STATUS_ADDR_DEFAULT = 32'hFFFF_FFFC;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

endpackage

// File: rtl/data_mem_bridge_dp_ram.sv
// Word RAM: one write port with async read for the core,
// plus an independent async read port for the dump engine.
module dp_ram #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addrA,
  input  logic [31:0]   wData,
  output logic [31:0]   rDataA,
  input  logic [AW-1:0] addrB,
  output logic [31:0]   rDataB
);

  logic [31:0] mem [DEPTH_WORDS];

  // Contents are intentionally left uninitialised across reset.
  always_ff @(posedge clk) begin
    if (we) mem[addrA] <= wData;
  end

  assign rDataA = mem[addrA];
  assign rDataB = mem[addrB];

endmodule

// File: rtl/data_mem_bridge.sv
// Memory stage bridge: data RAM, status register and a
// byte-stream dump engine triggered by the core's done flag.
module data_mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          DUMP_BASE   = 0,
  parameter int          DUMP_LEN    = 64,
  parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic        FlagZero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        dump_busy,
  output logic        dump_done
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int WCW = $clog2(DUMP_LEN) + 1;
  localparam logic [WCW-1:0] LastWord = WCW'(DUMP_LEN - 1);

  dump_state_t    state, stateNxt;
  logic [WCW-1:0] wordCnt, wordCntNxt;
  logic [1:0]     byteCnt, byteCntNxt;
  logic [31:0]    shadow, shadowNxt;
  logic           fzQ;

  logic           isStatus;
  logic           inRange;
  logic           memWe;
  logic [AW-1:0]  coreIdx;
  logic [AW-1:0]  dumpIdx;
  logic [31:0]    ramRd;
  logic [31:0]    dumpRd;
  logic [31:0]    statusWord;
  logic           trigger;

  assign isStatus = (ALUResult == STATUS_ADDR);
  assign inRange  = (ALUResult < 32'(DEPTH_WORDS * 4));
  assign coreIdx  = ALUResult[AW+1:2];
  assign memWe    = MemWrite & inRange & ~isStatus;
  assign dumpIdx  = AW'(DUMP_BASE) + AW'(wordCnt);

  dp_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) uRam (
    .clk   (clk),
    .we    (memWe),
    .addrA (coreIdx),
    .wData (WriteData),
    .rDataA(ramRd),
    .addrB (dumpIdx),
    .rDataB(dumpRd)
  );

  always_comb begin
    statusWord            = '0;
    statusWord[STAT_BUSY] = dump_busy;
    statusWord[STAT_DONE] = dump_done;
  end

  always_comb begin
    ReadData = '0;
    if (isStatus)     ReadData = statusWord;
    else if (inRange) ReadData = ramRd;
  end

  assign trigger   = FlagZero & ~fzQ;
  assign out_valid = (state == SEND);
  assign out_byte  = out_valid ? shadow[{byteCnt, 3'b000} +: 8] : '0;
  assign dump_busy = (state == LOAD) || (state == SEND);
  assign dump_done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      wordCnt <= '0;
      byteCnt <= '0;
      shadow  <= '0;
      fzQ     <= 1'b0;
    end else begin
      state   <= stateNxt;
      wordCnt <= wordCntNxt;
      byteCnt <= byteCntNxt;
      shadow  <= shadowNxt;
      fzQ     <= FlagZero;
    end
  end

  always_comb begin
    stateNxt   = state;
    wordCntNxt = wordCnt;
    byteCntNxt = byteCnt;
    shadowNxt  = shadow;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          stateNxt   = LOAD;
          wordCntNxt = '0;
        end
      end
      LOAD: begin
        // Shadow copy lets the core keep storing while bytes drain.
        shadowNxt  = dumpRd;
        byteCntNxt = '0;
        stateNxt   = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (byteCnt != 2'd3) begin
            byteCntNxt = byteCnt + 2'd1;
          end else if (wordCnt != LastWord) begin
            wordCntNxt = wordCnt + WCW'(1);
            stateNxt   = LOAD;
          end else begin
            stateNxt = DONE;
          end
        end
      end
      DONE: begin
        if (!FlagZero) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge: load/store table,
// then dump, backpressure, re-arm and reset-abort sequences.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        FlagZero;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        dump_busy;
  logic        dump_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];
  logic [7:0] s1[8];
  logic [7:0] s2[8];

  always #5 clk = ~clk;

  data_mem_bridge #(
    .DEPTH_WORDS(256),
    .DUMP_BASE  (0),
    .DUMP_LEN   (2),
    .STATUS_ADDR(32'hFFFF_FFFC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .FlagZero (FlagZero),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .dump_busy(dump_busy),
    .dump_done(dump_done)
  );

  // Mid-cycle sample; the handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) got.push_back(out_byte);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic waitBytes(input int n, input string name);
    int cyc = 0;
    while (got.size() < n && cyc < 200) begin
      tick(1);
      cyc++;
    end
    if (got.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d bytes, wanted %0d",
               name, got.size(), n);
    end
  endtask

  task automatic waitDone(input string name);
    int cyc = 0;
    while (!dump_done && cyc < 200) begin
      tick(1);
      cyc++;
    end
    chk(name, {31'b0, dump_done}, 32'd1);
  endtask

  task automatic checkStream(input logic [7:0] exp[8], input string name);
    chk({name, "_count"}, got.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) chk($sformatf("%s_b%0d", name, i), {24'b0, got[i]},
                              {24'b0, exp[i]});
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    ALUResult = a;
    WriteData = d;
    tick(1);
    MemWrite  = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h10,        32'h1111_1111, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h10,        32'hDEAD_BEEF, 1'b1, 32'h1111_1111};
    vecs[2]  = '{1'b0, 32'h10,        32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h11,        32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 32'h13,        32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 32'h0,         32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h3FC,       32'h0BAD_C0DE, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h400,       32'h1234_5678, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h400,       32'h0,         1'b1, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,         32'h0,         1'b1, 32'hCAFE_F00D};
    vecs[10] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};
    vecs[12] = '{1'b0, 32'h3FC,       32'h0,         1'b1, 32'h0BAD_C0DE};
    vecs[13] = '{1'b0, 32'hFFFF_FFF8, 32'h0,         1'b1, 32'h0};
    vecs[14] = '{1'b0, 32'h3FF,       32'h0,         1'b1, 32'h0BAD_C0DE};
    s1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    s2 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hDD, 8'hCC, 8'hBB, 8'hAA};

    reset     = 1'b0;
    MemWrite  = 1'b0;
    ALUResult = '0;
    WriteData = '0;
    FlagZero  = 1'b0;
    out_ready = 1'b0;
    tick(2);
    @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_byte",  {24'b0, out_byte},  32'd0);
    chk("rst_busy",  {31'b0, dump_busy}, 32'd0);
    chk("rst_done",  {31'b0, dump_done}, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    tick(1);

    for (int i = 0; i < 15; i++) begin
      MemWrite  = vecs[i].we;
      ALUResult = vecs[i].addr;
      WriteData = vecs[i].wd;
      @(negedge clk);
      if (vecs[i].chk) chk($sformatf("vec%0d", i), ReadData, vecs[i].exp);
      @(posedge clk);
      #2;
    end
    MemWrite = 1'b0;

    store(32'h0, 32'h0403_0201);
    store(32'h4, 32'h0807_0605);

    // First dump, consumer always ready.
    got.delete();
    ALUResult = 32'hFFFF_FFFC;
    out_ready = 1'b1;
    FlagZero  = 1'b1;
    tick(2);
    @(negedge clk);
    chk("stat_busy", ReadData, 32'd1);
    waitDone("dump1_done");
    @(negedge clk);
    chk("stat_done", ReadData, 32'd2);
    checkStream(s1, "dump1");

    // Done flag held: no second dump.
    tick(10);
    @(negedge clk);
    chk("hold_nobytes", got.size(), 32'd8);
    chk("hold_valid", {31'b0, out_valid}, 32'd0);
    chk("hold_done", {31'b0, dump_done}, 32'd1);

    // Re-arm, new word 1 data, then stall mid-word.
    @(posedge clk);
    #2;
    FlagZero = 1'b0;
    tick(1);
    @(negedge clk);
    chk("rearm_stat", ReadData, 32'd0);
    @(posedge clk);
    #2;
    store(32'h4, 32'hAABB_CCDD);
    got.delete();
    FlagZero = 1'b1;
    waitBytes(2, "dump2_pre");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_valid%0d", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("stall_byte%0d", i), {24'b0, out_byte}, 32'h03);
      @(posedge clk);
      #2;
    end
    out_ready = 1'b1;
    waitDone("dump2_done");
    checkStream(s2, "dump2");

    // Re-arm, then abort with reset after three bytes.
    FlagZero = 1'b0;
    tick(2);
    got.delete();
    FlagZero = 1'b1;
    waitBytes(3, "dump3_pre");
    reset = 1'b0;
    #1;
    chk("abort_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_busy", {31'b0, dump_busy}, 32'd0);
    tick(2);
    got.delete();
    reset = 1'b1;
    waitDone("dump4_done");
    checkStream(s2, "dump4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
